button_debouncer: RTL and testbench

//  Debounces NUM_BTN asynchronous push-buttons (ATM keypad/menu keys) against the slow

---
 rtl/button_debouncer.sv | 140 ++++++++++++++
 tb/tb_button_debouncer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Tick-qualified debouncer for NUM_BTN push-buttons. It produces
//                clean levels and one-clk press/release pulses. Defining
//                AUTO_REPEAT_EN adds hold-to-repeat press pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 3,
    parameter int CNT_W        = 2,
    parameter int HOLD_TICKS   = 10,
    parameter int REPEAT_TICKS = 3,
    parameter int RPT_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_in,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (STABLE_TICKS < 1 || (STABLE_TICKS - 1) > ((1 << CNT_W) - 1)) begin : g_chk_cnt_w
        $error("button_debouncer: CNT_W cannot hold STABLE_TICKS-1");
    end

    if (REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS
        || HOLD_TICKS > ((1 << RPT_W) - 1)) begin : g_chk_rpt_w
        $error("button_debouncer: bad HOLD_TICKS/REPEAT_TICKS/RPT_W combination");
    end

    logic [NUM_BTN-1:0]            sync1_q;
    logic [NUM_BTN-1:0]            sync2_q;
    logic                          tick_q;
    logic                          tick;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_BTN-1:0]            level_q;
    logic [NUM_BTN-1:0]            level_d;
    logic [NUM_BTN-1:0]            press_q;
    logic [NUM_BTN-1:0]            press_d;
    logic [NUM_BTN-1:0]            release_q;
    logic [NUM_BTN-1:0]            release_d;
    logic [NUM_BTN-1:0]            accept;

    // tick_q clears on reset, so a tick_in already high at release counts as a tick
    assign tick = tick_in & ~tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            tick_q    <= tick_in;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0] HOLD_VAL   = RPT_W'(HOLD_TICKS);
    localparam logic [RPT_W-1:0] RELOAD_VAL = RPT_W'(HOLD_TICKS - REPEAT_TICKS);

    logic [NUM_BTN-1:0][RPT_W-1:0] hcnt_q;
    logic [NUM_BTN-1:0][RPT_W-1:0] hcnt_d;
    logic [RPT_W-1:0]              hcnt_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`endif

    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        accept    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_LAST) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else begin
                    level_d[i]   = sync2_q[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                    accept[i]    = 1'b1;
                end
            end
        end
`ifdef AUTO_REPEAT_EN
        hcnt_d   = hcnt_q;
        hcnt_inc = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            hcnt_inc = hcnt_q[i] + RPT_ONE;
            // an acceptance edge always wins over a repeat on the same tick
            if (!level_q[i] || accept[i]) begin
                hcnt_d[i] = '0;
            end else if (tick) begin
                if (hcnt_inc == HOLD_VAL) begin
                    press_d[i] = 1'b1;
                    hcnt_d[i]  = RELOAD_VAL;
                end else begin
                    hcnt_d[i]  = hcnt_inc;
                end
            end
        end
`endif
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Randomized scoreboard bench for button_debouncer against a
//                run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_debouncer;

    localparam int NUM_BTN      = 4;
    localparam int STABLE_TICKS = 3;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD_TICKS   = 10;
    localparam int REPEAT_TICKS = 3;
`endif

    typedef struct packed {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       tick_in = 1'b0;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int checks = 0;
    int errors = 0;
    int tick_rises = 0;

    ev_t        exp_q[$];
    logic [3:0] m_level = 4'h0;

    always #5 clk = ~clk;

    button_debouncer dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // divider stand-in: tick_in toggles with a random half-period of 1..3 clks
    initial begin : tick_gen
        int cd;
        cd = 1;
        forever begin
            @(posedge clk);
            #2;
            if (cd <= 1) begin
                tick_in = ~tick_in;
                if (tick_in) tick_rises++;
                cd = $urandom_range(1, 3);
            end else begin
                cd--;
            end
        end
    end

    // Reference: sample seen 2 clks late, acceptance after STABLE_TICKS
    // consecutive differing ticks, repeats at fixed tick distances after press.
    logic [3:0] hist[$];
    logic       prev_tin;
    int         run[4];
    int         held[4];
    logic [3:0] smp;
    logic       tk;
    logic       was_one;
    logic       acc;
    ev_t        mdl_e;
    int         mdl_cyc;

    initial begin : model
        hist = {4'h0, 4'h0};
        prev_tin = 1'b0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; held[i] = 0; end
        forever begin
            @(posedge clk or negedge reset);
            mdl_cyc = int'($time) / 10;
            if (!reset) begin
                hist = {4'h0, 4'h0};
                prev_tin = 1'b0;
                m_level = 4'h0;
                for (int i = 0; i < 4; i++) begin run[i] = 0; held[i] = 0; end
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == mdl_cyc)
                    void'(exp_q.pop_back());
            end else begin
                smp = hist.pop_front();
                hist.push_back(btn_raw);
                tk = tick_in && !prev_tin;
                prev_tin = tick_in;
                mdl_e.cyc = mdl_cyc;
                mdl_e.press = 4'h0;
                mdl_e.rel = 4'h0;
                if (tk) begin
                    for (int i = 0; i < 4; i++) begin
                        was_one = m_level[i];
                        acc = 1'b0;
                        if (smp[i] == m_level[i]) begin
                            run[i] = 0;
                        end else begin
                            run[i] = run[i] + 1;
                            if (run[i] == STABLE_TICKS) begin
                                acc = 1'b1;
                                run[i] = 0;
                                m_level[i] = smp[i];
                                if (smp[i]) mdl_e.press[i] = 1'b1;
                                else        mdl_e.rel[i]   = 1'b1;
                            end
                        end
                        if (acc || !was_one) begin
                            held[i] = 0;
                        end else begin
                            held[i] = held[i] + 1;
`ifdef AUTO_REPEAT_EN
                            if (held[i] >= HOLD_TICKS && ((held[i] - HOLD_TICKS) % REPEAT_TICKS) == 0)
                                mdl_e.press[i] = 1'b1;
`endif
                        end
                    end
                end
                if ((mdl_e.press | mdl_e.rel) != 4'h0) exp_q.push_back(mdl_e);
            end
        end
    end

    ev_t mon_e;
    int  mon_cyc;

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_cyc = (int'($time) - 5) / 10;
            checks++;
            if (btn_level !== m_level) begin
                errors++;
                $display("FAIL level cyc=%0d actual=%b required=%b", mon_cyc, btn_level, m_level);
            end
            checks++;
            if ((btn_press & btn_release) !== 4'h0) begin
                errors++;
                $display("FAIL both_pulses cyc=%0d press=%b release=%b", mon_cyc, btn_press, btn_release);
            end
            if (btn_press !== 4'h0 || btn_release !== 4'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b required=none",
                             mon_cyc, btn_press, btn_release);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != mon_cyc || mon_e.press !== btn_press || mon_e.rel !== btn_release) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d actual press=%b release=%b required cyc=%0d press=%b release=%b",
                                 mon_cyc, btn_press, btn_release, mon_e.cyc, mon_e.press, mon_e.rel);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= mon_cyc) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                $display("FAIL missing_pulse cyc=%0d actual press=%b release=%b required press=%b release=%b",
                         mon_cyc, btn_press, btn_release, mon_e.press, mon_e.rel);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold_ticks(input int n);
        int target;
        int bound;
        target = tick_rises + n;
        bound = 0;
        while (tick_rises < target && bound < 20 * n + 20) begin
            step(1);
            bound++;
        end
        if (tick_rises < target) begin
            checks++;
            errors++;
            $display("FAIL tick_wait actual=%0d required=%0d", tick_rises, target);
        end
    endtask

    initial begin : stimulus
        // all outputs held at zero while reset is asserted with buttons pressed
        btn_raw = 4'hF;
        step(30);
        btn_raw = 4'h0;
        step(3);
        reset = 1'b1;
        hold_ticks(5);

        // clean press on bit 0
        btn_raw = 4'b0001;
        hold_ticks(6);

        // short bounce on bit 1
        btn_raw[1] = 1'b1;
        hold_ticks(2);
        btn_raw[1] = 1'b0;
        hold_ticks(5);

        // press then release on bit 2
        btn_raw[2] = 1'b1;
        hold_ticks(5);
        btn_raw[2] = 1'b0;
        hold_ticks(5);

        // simultaneous acceptance, then reset mid-count on bit 1
        btn_raw = 4'b0000;
        hold_ticks(5);
        btn_raw = 4'b1001;
        hold_ticks(5);
        btn_raw[1] = 1'b1;
        hold_ticks(2);
        reset = 1'b0;
        step(3);
        btn_raw[1] = 1'b0;
        reset = 1'b1;
        hold_ticks(6);

        // long hold on bit 3 for auto-repeat
        btn_raw = 4'b0000;
        hold_ticks(5);
        btn_raw = 4'b1000;
        hold_ticks(25);
        btn_raw = 4'b0000;
        hold_ticks(5);

        for (int k = 0; k < 300; k++) begin
            btn_raw = btn_raw ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                step($urandom_range(1, 4));
                reset = 1'b1;
            end
            step($urandom_range(1, 40));
        end

        btn_raw = 4'h0;
        hold_ticks(6);
        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
